// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics types, screen defaults and traversal states
package graphics_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;

  localparam int COORD_W = 17;  // [9].[8] unsigned fixed point
  localparam int FRAC_W  = 8;
  localparam int PIX_W   = 9;   // integer part of a coordinate
  localparam int AREA_W  = 34;  // [18].[16] unsigned fixed point

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [AREA_W-1:0]  area_t;

  // vertex[0] = x, vertex[1] = y
  typedef logic [1:0][COORD_W-1:0] vertex_t;
  typedef logic [1:0][PIX_W-1:0]   pix_vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN
  } traverse_state_t;

  // Floor of a non-negative fixed-point coordinate is its integer field.
  function automatic pix_t coord_floor(input coord_t c);
    return c[COORD_W-1:FRAC_W];
  endfunction

endpackage

// File: rtl/triangle_bbox.sv
// rtl/triangle_bbox.sv - screen-clamped integer bounding box of three vertices
module triangle_bbox
  import graphics_pkg::*;
#(
  parameter int WIDTH  = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [2:0][1:0][8:0]  verts_i,
  output logic [8:0]            start_x_o,
  output logic [8:0]            start_y_o,
  output logic                  offscreen_o,
  output logic [8:0]            xmin_o,
  output logic [8:0]            xmax_o,
  output logic [8:0]            ymax_o
);

  localparam pix_t X_LAST = pix_t'(WIDTH - 1);
  localparam pix_t Y_LAST = pix_t'(HEIGHT - 1);

  pix_t min_x, min_y, max_x, max_y;
  pix_t xmax_d, ymax_d;
  pix_t xmin_q, xmax_q, ymax_q;

  // Min/max over the three integer vertex coordinates, then clamp the far edge to the screen.
  always_comb begin
    min_x = verts_i[0][0];
    max_x = verts_i[0][0];
    min_y = verts_i[0][1];
    max_y = verts_i[0][1];
    for (int i = 1; i < 3; i++) begin
      if (verts_i[i][0] < min_x) min_x = verts_i[i][0];
      if (verts_i[i][0] > max_x) max_x = verts_i[i][0];
      if (verts_i[i][1] < min_y) min_y = verts_i[i][1];
      if (verts_i[i][1] > max_y) max_y = verts_i[i][1];
    end
    xmax_d = (max_x > X_LAST) ? X_LAST : max_x;
    ymax_d = (max_y > Y_LAST) ? Y_LAST : max_y;
  end

  assign start_x_o   = min_x;
  assign start_y_o   = min_y;
  assign offscreen_o = (min_x > X_LAST) || (min_y > Y_LAST);

  // Hold the box edges needed during the scan; loaded during the setup cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else if (load_i) begin
      xmin_q <= min_x;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
    end
  end

  assign xmin_o = xmin_q;
  assign xmax_o = xmax_q;
  assign ymax_o = ymax_q;

endmodule

// File: rtl/triangle_traverse.sv
// rtl/triangle_traverse.sv - cull triangles and scan their bounding box row-major; TRIANGLE_TRAVERSE_BACKFACE_CULL_EN drops clockwise triangles
module triangle_traverse
  import graphics_pkg::*;
#(
  parameter int WIDTH  = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [2:0][1:0][16:0] vertices_in,
  input  logic [33:0]           area_in,
  input  logic                  negative_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [8:0]            x_out,
  output logic [8:0]            y_out,
  output logic                  last_out,
  output logic [33:0]           area_out,
  output logic                  negative_out,
  output logic                  culled_out
);

  traverse_state_t state_q, state_d;
  logic [2:0][1:0][8:0] verts_q, verts_d;
  area_t  area_q, area_d;
  logic   neg_q, neg_d;
  pix_t   x_q, x_d, y_q, y_d;
  logic   culled_q, culled_d;

  logic   bbox_load;
  pix_t   start_x, start_y, xmin, xmax, ymax;
  logic   offscreen;
  logic   drop_winding;
  logic   at_row_end, at_last;
  logic [2:0][1:0][8:0] verts_int;
  logic   unused_frac;

  // Only the integer part of each coordinate matters once the triangle is captured.
  always_comb begin
    verts_int   = '0;
    unused_frac = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        verts_int[i][j] = coord_floor(vertices_in[i][j]);
        unused_frac     = unused_frac ^ (^vertices_in[i][j][FRAC_W-1:0]);
      end
    end
  end

`ifdef TRIANGLE_TRAVERSE_BACKFACE_CULL_EN
  assign drop_winding = negative_in;
`else
  assign drop_winding = 1'b0;
`endif

  triangle_bbox #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_bbox (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .load_i      (bbox_load),
    .verts_i     (verts_q),
    .start_x_o   (start_x),
    .start_y_o   (start_y),
    .offscreen_o (offscreen),
    .xmin_o      (xmin),
    .xmax_o      (xmax),
    .ymax_o      (ymax)
  );

  assign at_row_end = (x_q == xmax);
  assign at_last    = at_row_end && (y_q == ymax);

  // Next-state and datapath updates for accept, setup and scan.
  always_comb begin
    state_d   = state_q;
    verts_d   = verts_q;
    area_d    = area_q;
    neg_d     = neg_q;
    x_d       = x_q;
    y_d       = y_q;
    culled_d  = 1'b0;
    bbox_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if ((area_in == '0) || drop_winding) begin
            culled_d = 1'b1;
          end else begin
            verts_d = verts_int;
            area_d  = area_in;
            neg_d   = negative_in;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        bbox_load = 1'b1;
        if (offscreen) begin
          culled_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          x_d     = start_x;
          y_d     = start_y;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (ready_in) begin
          if (at_last) begin
            state_d = ST_IDLE;
          end else if (at_row_end) begin
            x_d = xmin;
            y_d = pix_t'(y_q + 9'd1);
          end else begin
            x_d = pix_t'(x_q + 9'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any triangle in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      verts_q  <= '0;
      area_q   <= '0;
      neg_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      culled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      verts_q  <= verts_d;
      area_q   <= area_d;
      neg_q    <= neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      culled_q <= culled_d;
    end
  end

  assign ready_out    = (state_q == ST_IDLE);
  assign valid_out    = (state_q == ST_SCAN);
  assign last_out     = valid_out && at_last;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign area_out     = area_q;
  assign negative_out = neg_q;
  assign culled_out   = culled_q;

endmodule
